// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: the buffered FU result record and
// the default geometry that sizes it.
package wb_pkg;

    localparam int DEF_FU_COUNT     = 4;
    localparam int DEF_WB_PORTS     = 2;
    localparam int DEF_FIFO_DEPTH   = 2;
    localparam int DEF_INST_ID_BITS = 6;
    localparam int DEF_PRN_BITS     = 6;
    localparam int DEF_MAX_OPERANDS = 3;

    localparam int FU_IDX_BITS = $clog2(DEF_FU_COUNT);

    typedef struct packed {
        logic [DEF_INST_ID_BITS-1:0]                     inst_id;
        logic [DEF_MAX_OPERANDS-1:0][DEF_PRN_BITS-1:0]   prn;
        logic [DEF_MAX_OPERANDS-1:0][63:0]               data;
        logic [DEF_MAX_OPERANDS-1:0]                     data_valid;
    } fu_result_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Per-FU skid FIFO of writeback results. Reset and flush both empty it; the
// storage array itself is not cleared because nothing reads an empty slot.
module wb_skid_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = DEF_FIFO_DEPTH,
    parameter type T     = fu_result_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  T                         din,
    output logic [$clog2(DEPTH):0]   count,
    output T                         head,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T               mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    assign head = mem[rd_ptr];
    assign full = (count == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers each FU result in a skid FIFO and retires up to
// WB_PORTS heads per cycle in round-robin order onto the PRF write/wakeup ports.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int FU_COUNT     = DEF_FU_COUNT,
    parameter int WB_PORTS     = DEF_WB_PORTS,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int INST_ID_BITS = DEF_INST_ID_BITS,
    parameter int PRN_BITS     = DEF_PRN_BITS,
    parameter int MAX_OPERANDS = DEF_MAX_OPERANDS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    // Handshake: a result moves into FIFO i on an edge where fu_out_valid[i]
    // is high, fu_stall[i] is low and flush is low; while stalled the FU holds it.
    input  logic                     fu_out_valid      [FU_COUNT],
    input  logic [INST_ID_BITS-1:0]  fu_out_inst_id    [FU_COUNT],
    input  logic [PRN_BITS-1:0]      fu_out_prn        [FU_COUNT][MAX_OPERANDS],
    input  logic [63:0]              fu_out_data       [FU_COUNT][MAX_OPERANDS],
    input  logic                     fu_out_data_valid [FU_COUNT][MAX_OPERANDS],
    output logic                     fu_stall          [FU_COUNT],
    output logic                     wb_valid          [WB_PORTS],
    output logic [FU_IDX_BITS-1:0]   wb_fu_idx         [WB_PORTS],
    output logic [INST_ID_BITS-1:0]  wb_inst_id        [WB_PORTS],
    output logic [PRN_BITS-1:0]      wb_prn            [WB_PORTS][MAX_OPERANDS],
    output logic [63:0]              wb_data           [WB_PORTS][MAX_OPERANDS],
    output logic                     wb_data_valid     [WB_PORTS][MAX_OPERANDS]
);
    localparam int CNT_BITS = $clog2(FIFO_DEPTH) + 1;

    fu_result_t             push_data [FU_COUNT];
    fu_result_t             head      [FU_COUNT];
    fu_result_t             wb_sel    [WB_PORTS];
    logic [CNT_BITS-1:0]    count     [FU_COUNT];
    int                     scan_rank [FU_COUNT];
    logic [FU_COUNT-1:0]    push;
    logic [FU_COUNT-1:0]    full;
    logic [FU_COUNT-1:0]    non_empty;
    logic [FU_COUNT-1:0]    grant;
    logic [FU_IDX_BITS-1:0] rr_ptr;
    logic [FU_IDX_BITS-1:0] rr_next;
    logic                   any_grant;

    // Stall looks only at registered occupancy, never at this cycle's pop.
    always_comb begin
        for (int i = 0; i < FU_COUNT; i++) begin
            push_data[i]         = '0;
            push_data[i].inst_id = fu_out_inst_id[i];
            for (int s = 0; s < MAX_OPERANDS; s++) begin
                push_data[i].prn[s]        = fu_out_prn[i][s];
                push_data[i].data[s]       = fu_out_data[i][s];
                push_data[i].data_valid[s] = fu_out_data_valid[i][s];
            end
            push[i]      = fu_out_valid[i] && !full[i] && !flush;
            non_empty[i] = (count[i] != '0);
            fu_stall[i]  = full[i];
        end
    end

    for (genvar g = 0; g < FU_COUNT; g++) begin : g_fifo
        wb_skid_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[g]),
            .pop   (grant[g]),
            .din   (push_data[g]),
            .count (count[g]),
            .head  (head[g]),
            .full  (full[g])
        );
    end

    // Each FU's rank is the number of candidates ahead of it in the scan that
    // starts at rr_ptr; rank r (< WB_PORTS) is granted onto port r.
    always_comb begin
        int scan_off [FU_COUNT];
        int best_off;
        best_off = -1;
        grant    = '0;
        rr_next  = rr_ptr;
        for (int j = 0; j < FU_COUNT; j++) begin
            scan_off[j] = (j - int'(rr_ptr) + FU_COUNT) % FU_COUNT;
        end
        for (int j = 0; j < FU_COUNT; j++) begin
            scan_rank[j] = 0;
            for (int k = 0; k < FU_COUNT; k++) begin
                if (non_empty[k] && scan_off[k] < scan_off[j]) scan_rank[j] = scan_rank[j] + 1;
            end
        end
        for (int j = 0; j < FU_COUNT; j++) begin
            if (!flush && non_empty[j] && scan_rank[j] < WB_PORTS) begin
                grant[j] = 1'b1;
                if (scan_off[j] > best_off) begin
                    best_off = scan_off[j];
                    rr_next  = FU_IDX_BITS'((j + 1) % FU_COUNT);
                end
            end
        end
    end

    assign any_grant = |grant;

    always_comb begin
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_sel[p]    = '0;
            wb_valid[p]  = 1'b0;
            wb_fu_idx[p] = '0;
            for (int j = 0; j < FU_COUNT; j++) begin
                if (grant[j] && scan_rank[j] == p) begin
                    wb_sel[p]    = head[j];
                    wb_valid[p]  = 1'b1;
                    wb_fu_idx[p] = FU_IDX_BITS'(j);
                end
            end
            wb_inst_id[p] = wb_sel[p].inst_id;
            for (int s = 0; s < MAX_OPERANDS; s++) begin
                wb_prn[p][s]        = wb_sel[p].prn[s];
                wb_data[p][s]       = wb_sel[p].data[s];
                wb_data_valid[p][s] = wb_sel[p].data_valid[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (any_grant) begin
            rr_ptr <= rr_next;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model of the round-robin writeback rules.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int NF    = 4;
    localparam int NP    = 2;
    localparam int DEPTH = 2;
    localparam int NS    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        fu_out_valid      [NF];
    logic [5:0]  fu_out_inst_id    [NF];
    logic [5:0]  fu_out_prn        [NF][NS];
    logic [63:0] fu_out_data       [NF][NS];
    logic        fu_out_data_valid [NF][NS];
    logic        fu_stall          [NF];
    logic        wb_valid          [NP];
    logic [1:0]  wb_fu_idx         [NP];
    logic [5:0]  wb_inst_id        [NP];
    logic [5:0]  wb_prn            [NP][NS];
    logic [63:0] wb_data           [NP][NS];
    logic        wb_data_valid     [NP][NS];

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per FU and a scan start pointer.
    fu_result_t mq [NF][$];
    int         m_rr;
    logic       exp_valid [NP];
    int         exp_idx   [NP];
    fu_result_t exp_res   [NP];

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .fu_out_valid      (fu_out_valid),
        .fu_out_inst_id    (fu_out_inst_id),
        .fu_out_prn        (fu_out_prn),
        .fu_out_data       (fu_out_data),
        .fu_out_data_valid (fu_out_data_valid),
        .fu_stall          (fu_stall),
        .wb_valid          (wb_valid),
        .wb_fu_idx         (wb_fu_idx),
        .wb_inst_id        (wb_inst_id),
        .wb_prn            (wb_prn),
        .wb_data           (wb_data),
        .wb_data_valid     (wb_data_valid)
    );

    // ---------------- clock / reset ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        for (int i = 0; i < NF; i++) begin
            fu_out_valid[i]   = 1'b0;
            fu_out_inst_id[i] = '0;
            for (int s = 0; s < NS; s++) begin
                fu_out_prn[i][s]        = '0;
                fu_out_data[i][s]       = '0;
                fu_out_data_valid[i][s] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        flush = 1'b0;
        drive_idle();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < NF; i++) mq[i].delete();
        m_rr = 0;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_fu(input int i, input logic [5:0] id, input logic [5:0] p0);
        fu_out_valid[i]   = 1'b1;
        fu_out_inst_id[i] = id;
        for (int s = 0; s < NS; s++) begin
            fu_out_prn[i][s]        = (s == 0) ? p0 : 6'd0;
            fu_out_data[i][s]       = (s == 0) ? {58'd0, id} : 64'd0;
            fu_out_data_valid[i][s] = (s == 0);
        end
    endtask

    task automatic drive_random();
        for (int i = 0; i < NF; i++) begin
            fu_out_valid[i]   = ($urandom_range(0, 9) < 6);
            fu_out_inst_id[i] = 6'($urandom);
            for (int s = 0; s < NS; s++) begin
                fu_out_prn[i][s]        = 6'($urandom);
                fu_out_data[i][s]       = {$urandom, $urandom};
                fu_out_data_valid[i][s] = 1'($urandom);
            end
        end
        flush = ($urandom_range(0, 39) == 0);
    endtask

    function automatic fu_result_t input_res(int i);
        fu_result_t r;
        r = '0;
        r.inst_id = fu_out_inst_id[i];
        for (int s = 0; s < NS; s++) begin
            r.prn[s]        = fu_out_prn[i][s];
            r.data[s]       = fu_out_data[i][s];
            r.data_valid[s] = fu_out_data_valid[i][s];
        end
        return r;
    endfunction

    function automatic fu_result_t port_res(int p);
        fu_result_t r;
        r = '0;
        r.inst_id = wb_inst_id[p];
        for (int s = 0; s < NS; s++) begin
            r.prn[s]        = wb_prn[p][s];
            r.data[s]       = wb_data[p][s];
            r.data_valid[s] = wb_data_valid[p][s];
        end
        return r;
    endfunction

    // ---------------- model ----------------
    function automatic void model_eval();
        int n;
        n = 0;
        for (int p = 0; p < NP; p++) begin
            exp_valid[p] = 1'b0;
            exp_idx[p]   = 0;
            exp_res[p]   = '0;
        end
        for (int k = 0; k < NF; k++) begin
            int f;
            f = (m_rr + k) % NF;
            if (!flush && mq[f].size() > 0 && n < NP) begin
                exp_valid[n] = 1'b1;
                exp_idx[n]   = f;
                exp_res[n]   = mq[f][0];
                n++;
            end
        end
    endfunction

    function automatic void model_edge();
        bit was_full [NF];
        if (rst) begin
            for (int i = 0; i < NF; i++) mq[i].delete();
            m_rr = 0;
            return;
        end
        if (flush) begin
            for (int i = 0; i < NF; i++) mq[i].delete();
            return;
        end
        for (int i = 0; i < NF; i++) was_full[i] = (mq[i].size() == DEPTH);
        for (int p = 0; p < NP; p++) begin
            if (exp_valid[p]) begin
                void'(mq[exp_idx[p]].pop_front());
                m_rr = (exp_idx[p] + 1) % NF;
            end
        end
        for (int i = 0; i < NF; i++) begin
            if (fu_out_valid[i] && !was_full[i]) mq[i].push_back(input_res(i));
        end
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (wb_valid[p] !== 1'b0 || port_res(p) !== '0 || wb_fu_idx[p] !== 2'd0) begin
                errors++;
                $display("FAIL reset_wb%0d: valid=%0b idx=%0d payload=%h, required all zero",
                         p, wb_valid[p], wb_fu_idx[p], port_res(p));
            end
        end
        for (int i = 0; i < NF; i++) begin
            checks++;
            if (fu_stall[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_stall%0d: got %0b, required 0", i, fu_stall[i]);
            end
        end
        checks++;
        if (dut.rr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL reset_rr: got %0d, required 0", dut.rr_ptr);
        end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        drive_fu(2, 6'd5, 6'd7);
        @(negedge clk);
        checks++;
        if (wb_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: wb_valid[0]=%0b in accept cycle, required 0", wb_valid[0]);
        end
        tick();
        drive_idle();
        @(negedge clk);
        checks++;
        if (wb_valid[0] !== 1'b1 || wb_fu_idx[0] !== 2'd2 || wb_inst_id[0] !== 6'd5) begin
            errors++;
            $display("FAIL single_port0: valid=%0b idx=%0d id=%0d, required 1/2/5",
                     wb_valid[0], wb_fu_idx[0], wb_inst_id[0]);
        end
        checks++;
        if (wb_prn[0][0] !== 6'd7 || wb_data_valid[0][0] !== 1'b1 ||
            wb_data_valid[0][1] !== 1'b0 || wb_data_valid[0][2] !== 1'b0) begin
            errors++;
            $display("FAIL single_slots: prn0=%0d dv=%0b%0b%0b, required prn0=7 dv=100",
                     wb_prn[0][0], wb_data_valid[0][0], wb_data_valid[0][1], wb_data_valid[0][2]);
        end
        checks++;
        if (wb_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL single_port1: wb_valid[1]=%0b, required 0", wb_valid[1]);
        end
        tick();
        checks++;
        if (dut.rr_ptr !== 2'd3) begin
            errors++;
            $display("FAIL single_rr: got %0d, required 3", dut.rr_ptr);
        end
        @(negedge clk);
        checks++;
        if (wb_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_dup: wb_valid[0]=%0b after retire, required 0", wb_valid[0]);
        end
        tick();
    endtask

    // Every FU always valid and holding its result while stalled; ids are
    // FU*16 + per-FU sequence so loss or duplication shows up as a gap.
    task automatic test_all_valid();
        int  seq_in  [NF];
        int  seq_out [NF];
        do_reset();
        for (int i = 0; i < NF; i++) begin
            seq_in[i]  = 0;
            seq_out[i] = 0;
        end
        for (int c = 1; c <= 12; c++) begin
            for (int i = 0; i < NF; i++) drive_fu(i, 6'(i * 16 + seq_in[i]), 6'(i + 1));
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                int exp_f;
                exp_f = ((c % 2 == 0) ? 0 : 2) + p;
                checks++;
                if (c == 1) begin
                    if (wb_valid[p] !== 1'b0) begin
                        errors++;
                        $display("FAIL allv_first c=%0d port%0d: valid=%0b, required 0", c, p, wb_valid[p]);
                    end
                end else if (wb_valid[p] !== 1'b1 || wb_fu_idx[p] !== 2'(exp_f)) begin
                    errors++;
                    $display("FAIL allv_pair c=%0d port%0d: valid=%0b idx=%0d, required 1/%0d",
                             c, p, wb_valid[p], wb_fu_idx[p], exp_f);
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (wb_valid[p] === 1'b1) begin
                    int f;
                    f = int'(wb_fu_idx[p]);
                    checks++;
                    if (wb_inst_id[p] !== 6'(f * 16 + seq_out[f])) begin
                        errors++;
                        $display("FAIL allv_order c=%0d fu%0d: id=%0d, required %0d",
                                 c, f, wb_inst_id[p], f * 16 + seq_out[f]);
                    end
                    seq_out[f]++;
                end
            end
            for (int i = 0; i < NF; i++) begin
                logic exp_st;
                exp_st = (i < 2) ? (c >= 4 && c % 2 == 0) : (c >= 3 && c % 2 == 1);
                checks++;
                if (fu_stall[i] !== exp_st) begin
                    errors++;
                    $display("FAIL allv_stall c=%0d fu%0d: got %0b, required %0b", c, i, fu_stall[i], exp_st);
                end
            end
            if (c >= 5 && c % 2 == 1) begin
                checks++;
                if (dut.g_fifo[0].u_fifo.count !== 2'd1) begin
                    errors++;
                    $display("FAIL full_pop c=%0d: fu0 count=%0d, required 1",
                             c, dut.g_fifo[0].u_fifo.count);
                end
            end
            for (int i = 0; i < NF; i++) if (fu_stall[i] === 1'b0) seq_in[i]++;
            tick();
        end
        drive_idle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (wb_valid[p] === 1'b1) begin
                    int f;
                    f = int'(wb_fu_idx[p]);
                    checks++;
                    if (wb_inst_id[p] !== 6'(f * 16 + seq_out[f])) begin
                        errors++;
                        $display("FAIL allv_drain fu%0d: id=%0d, required %0d",
                                 f, wb_inst_id[p], f * 16 + seq_out[f]);
                    end
                    seq_out[f]++;
                end
            end
            tick();
        end
        for (int i = 0; i < NF; i++) begin
            checks++;
            if (seq_out[i] != seq_in[i]) begin
                errors++;
                $display("FAIL allv_count fu%0d: retired %0d, required %0d", i, seq_out[i], seq_in[i]);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 1; i < NF; i++) drive_fu(i, 6'(10 + i), 6'(i));
        tick();
        for (int i = 1; i < NF; i++) drive_fu(i, 6'(20 + i), 6'(i));
        @(negedge clk);
        checks++;
        if (wb_valid[0] !== 1'b1 || wb_fu_idx[0] !== 2'd1 || wb_valid[1] !== 1'b1 || wb_fu_idx[1] !== 2'd2) begin
            errors++;
            $display("FAIL flush_pre: ports %0b/%0d %0b/%0d, required 1/1 1/2",
                     wb_valid[0], wb_fu_idx[0], wb_valid[1], wb_fu_idx[1]);
        end
        tick();
        drive_idle();
        drive_fu(0, 6'd9, 6'd9);
        flush = 1'b1;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (wb_valid[p] !== 1'b0 || wb_data_valid[p][0] !== 1'b0) begin
                errors++;
                $display("FAIL flush_cycle port%0d: valid=%0b dv0=%0b, required 0/0",
                         p, wb_valid[p], wb_data_valid[p][0]);
            end
        end
        tick();
        flush = 1'b0;
        drive_idle();
        checks++;
        if (dut.rr_ptr !== 2'd3) begin
            errors++;
            $display("FAIL flush_rr: got %0d, required 3", dut.rr_ptr);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                checks++;
                if (wb_valid[p] !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_after c=%0d port%0d: valid=%0b, required 0", c, p, wb_valid[p]);
                end
            end
            for (int i = 0; i < NF; i++) begin
                checks++;
                if (fu_stall[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_stall c=%0d fu%0d: got %0b, required 0", c, i, fu_stall[i]);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive_fu(1, 6'(30 + c), 6'd1);
            drive_fu(2, 6'(40 + c), 6'd2);
            tick();
        end
        checks++;
        if (dut.rr_ptr !== 2'd3) begin
            errors++;
            $display("FAIL rstmid_pre_rr: got %0d, required 3", dut.rr_ptr);
        end
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        drive_idle();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                checks++;
                if (wb_valid[p] !== 1'b0 || port_res(p) !== '0) begin
                    errors++;
                    $display("FAIL rstmid_wb c=%0d port%0d: valid=%0b payload=%h, required all zero",
                             c, p, wb_valid[p], port_res(p));
                end
            end
            for (int i = 0; i < NF; i++) begin
                checks++;
                if (fu_stall[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL rstmid_stall c=%0d fu%0d: got %0b, required 0", c, i, fu_stall[i]);
                end
            end
            checks++;
            if (dut.rr_ptr !== 2'd0) begin
                errors++;
                $display("FAIL rstmid_rr c=%0d: got %0d, required 0", c, dut.rr_ptr);
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive_random();
            @(negedge clk);
            model_eval();
            for (int p = 0; p < NP; p++) begin
                checks++;
                if (wb_valid[p] !== exp_valid[p]) begin
                    errors++;
                    $display("FAIL rand_valid c=%0d port%0d: got %0b, required %0b",
                             c, p, wb_valid[p], exp_valid[p]);
                end else if (exp_valid[p]) begin
                    checks++;
                    if (wb_fu_idx[p] !== 2'(exp_idx[p]) || port_res(p) !== exp_res[p]) begin
                        errors++;
                        $display("FAIL rand_payload c=%0d port%0d: idx=%0d res=%h, required idx=%0d res=%h",
                                 c, p, wb_fu_idx[p], port_res(p), exp_idx[p], exp_res[p]);
                    end
                end else begin
                    checks++;
                    if (port_res(p).data_valid !== '0) begin
                        errors++;
                        $display("FAIL rand_dv c=%0d port%0d: dv=%b on idle port, required 000",
                                 c, p, port_res(p).data_valid);
                    end
                end
            end
            for (int i = 0; i < NF; i++) begin
                checks++;
                if (fu_stall[i] !== (mq[i].size() == DEPTH)) begin
                    errors++;
                    $display("FAIL rand_stall c=%0d fu%0d: got %0b, required %0b",
                             c, i, fu_stall[i], mq[i].size() == DEPTH);
                end
            end
            checks++;
            if (dut.rr_ptr !== 2'(m_rr)) begin
                errors++;
                $display("FAIL rand_rr c=%0d: got %0d, required %0d", c, dut.rr_ptr, m_rr);
            end
            model_edge();
            tick();
        end
        flush = 1'b0;
        drive_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        m_rr  = 0;
        drive_idle();
        test_reset();
        test_single();
        test_all_valid();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
